// File: rtl/mult_div_pkg.sv
// Shared constants for the multicycle signed multiply/divide unit:
// FSM state encodings, operation codes and the iteration counter width.
package mult_div_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = $clog2(DEF_DATA_W);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MULT_RUN = 2'd1;
  localparam logic [1:0] DIV_RUN  = 2'd2;
  localparam logic [1:0] FINISH   = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit/datapath (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              start;
  logic              op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division step on magnitudes: trial-subtract the divisor from
// the shifted partial remainder and keep the difference only if it is non-negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   part_rem,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic              q_bit
);

  // The remainder stays below the divisor, so a successful subtraction fits in DATA_W bits.
  always_comb begin
    q_bit    = (part_rem >= {1'b0, divisor});
    next_rem = q_bit ? DATA_W'(part_rem - {1'b0, divisor}) : part_rem[DATA_W-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, on magnitudes) unit
// producing the Hi/Lo pair; one iteration per clock, DATA_W iterations per operation.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              dz_flag;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] mplier;
  logic              booth_bit;

  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] dq;
  logic [DATA_W-1:0] rem;
  logic              neg_quo;
  logic              neg_rem;

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  logic [DATA_W:0]     mcand_ext;
  logic [DATA_W:0]     booth_sum;
  logic [DATA_W:0]     acc_next;
  logic [DATA_W-1:0]   mplier_next;
  logic [2*DATA_W-1:0] product;

  logic [DATA_W:0]   part_rem;
  logic [DATA_W-1:0] rem_next;
  logic              q_bit;
  logic [DATA_W-1:0] quo_next;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  // The accumulator carries one guard bit so that subtracting the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    mcand_ext = {mcand[DATA_W-1], mcand};
    case ({mplier[0], booth_bit})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    acc_next    = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
    mplier_next = {booth_sum[0], mplier[DATA_W-1:1]};
    product     = {acc_next[DATA_W-1:0], mplier_next};
  end

  assign part_rem = {rem, dq[DATA_W-1]};
  assign quo_next = {dq[DATA_W-2:0], q_bit};

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .part_rem (part_rem),
    .divisor  (divisor),
    .next_rem (rem_next),
    .q_bit    (q_bit)
  );

  assign a_mag = bus.a[DATA_W-1] ? -bus.a : bus.a;
  assign b_mag = bus.b[DATA_W-1] ? -bus.b : bus.b;

  // Hi/Lo are loaded on the edge entering FINISH so they are already valid
  // while Done is high; a div-by-zero request leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dz_flag   <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      booth_bit <= 1'b0;
      divisor   <= '0;
      dq        <= '0;
      rem       <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt <= '0;
            case (bus.op)
              OP_MULT: begin
                mcand     <= bus.a;
                mplier    <= bus.b;
                acc       <= '0;
                booth_bit <= 1'b0;
                state     <= MULT_RUN;
              end
              OP_DIV: begin
                if (bus.b == '0) begin
                  dz_flag <= 1'b1;
                  state   <= FINISH;
                end else begin
                  rem     <= '0;
                  dq      <= a_mag;
                  divisor <= b_mag;
                  neg_rem <= bus.a[DATA_W-1];
                  neg_quo <= bus.a[DATA_W-1] ^ bus.b[DATA_W-1];
                  state   <= DIV_RUN;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end

        MULT_RUN: begin
          acc       <= acc_next;
          mplier    <= mplier_next;
          booth_bit <= mplier[0];
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            hi    <= product[2*DATA_W-1:DATA_W];
            lo    <= product[DATA_W-1:0];
            state <= FINISH;
          end
        end

        // Truncating signed division: quotient sign from sign(A)^sign(B),
        // remainder sign from the dividend.
        DIV_RUN: begin
          rem <= rem_next;
          dq  <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            hi    <= neg_rem ? -rem_next : rem_next;
            lo    <= neg_quo ? -quo_next : quo_next;
            state <= FINISH;
          end
        end

        FINISH: begin
          dz_flag <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);
  assign bus.div_zero = (state == FINISH) && dz_flag;
  assign bus.hi       = hi;
  assign bus.lo       = lo;

endmodule
